// File: rtl/seg7_pkg.sv
// Shared segment patterns (gfedcba, active-high), decoded codes and scan FSM states for the 7-segment reader.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [3:0] CODE_BLANK = 4'hA;
  localparam logic [3:0] CODE_DASH  = 4'hE;
  localparam logic [3:0] CODE_INV   = 4'hF;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } scan_state_t;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational segment-pattern decoder: 7-bit gfedcba pattern to 4-bit code plus error flag.
// Build option SEG7_BLANK_DETECT_EN: an all-dark digit decodes to CODE_BLANK without error.
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code,
  output logic       err
);

  always_comb begin
    code = CODE_INV;
    err  = 1'b1;
    case (seg)
      SEG_0:    begin code = 4'd0;      err = 1'b0; end
      SEG_1:    begin code = 4'd1;      err = 1'b0; end
      SEG_2:    begin code = 4'd2;      err = 1'b0; end
      SEG_3:    begin code = 4'd3;      err = 1'b0; end
      SEG_4:    begin code = 4'd4;      err = 1'b0; end
      SEG_5:    begin code = 4'd5;      err = 1'b0; end
      SEG_6:    begin code = 4'd6;      err = 1'b0; end
      SEG_7:    begin code = 4'd7;      err = 1'b0; end
      SEG_8:    begin code = 4'd8;      err = 1'b0; end
      SEG_9:    begin code = 4'd9;      err = 1'b0; end
      SEG_DASH: begin code = CODE_DASH; err = 1'b0; end
`ifdef SEG7_BLANK_DETECT_EN
      SEG_BLANK: begin code = CODE_BLANK; err = 1'b0; end
`else
      SEG_BLANK: begin code = CODE_INV;   err = 1'b1; end
`endif
      default: begin code = CODE_INV; err = 1'b1; end
    endcase
  end

endmodule

// File: rtl/seg7_scan_reader.sv
// Reads a multiplexed 4-digit 7-segment scan, debounces each digit dwell and assembles frames with a valid/ack handshake.
// Build option SEG7_BLANK_DETECT_EN (in seg7_to_bcd) makes a blank digit a legal code.
module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CNT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [6:0]  SEG,
  input  logic [3:0]  DIG,
  output logic [15:0] OUT,
  output logic        VALID,
  input  logic        ACK,
  output logic        ERR,
  output logic        OVR
);

  localparam logic [7:0] STABLE_TGT = 8'(STABLE_CNT);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [6:0]  seg_p0, seg_p1, seg_p2;
  logic [3:0]  dig_p0, dig_p1, dig_p2;
  logic [7:0]  stab_cnt, stab_cnt_n;
  logic        dig_onehot, same_as_prev, capture;
  logic [3:0]  dec_code;
  logic        dec_err;
  logic [3:0]  slot_code [4];
  logic [3:0]  slot_err;
  logic [3:0]  mask;
  scan_state_t state, state_n;
  logic        load, drop, ack_clr;

  // p0/p1: two-flop synchroniser; p2: previous synchronised sample
  always_ff @(posedge CLK) begin
    if (RST) begin
      seg_p0 <= '0;
      seg_p1 <= '0;
      seg_p2 <= '0;
      dig_p0 <= '0;
      dig_p1 <= '0;
      dig_p2 <= '0;
    end else begin
      seg_p0 <= SEG;
      seg_p1 <= seg_p0;
      seg_p2 <= seg_p1;
      dig_p0 <= DIG;
      dig_p1 <= dig_p0;
      dig_p2 <= dig_p1;
    end
  end

  always_comb begin
    dig_onehot   = $onehot(dig_p1);
    same_as_prev = (dig_p1 == dig_p2) && (seg_p1 == seg_p2);
    stab_cnt_n   = 8'd0;
    capture      = 1'b0;
    if (dig_onehot) begin
      stab_cnt_n = same_as_prev ? sat_inc8(stab_cnt) : 8'd1;
      // A restart that lands on the target (STABLE_CNT=1) is a new dwell; a held target is not
      capture    = (stab_cnt_n == STABLE_TGT) && (!same_as_prev || (stab_cnt != STABLE_TGT));
    end
  end

  seg7_to_bcd u_dec (
    .seg  (seg_p1),
    .code (dec_code),
    .err  (dec_err)
  );

  always_ff @(posedge CLK) begin
    for (int i = 0; i < 4; i++) begin
      if (capture && dig_p1[i]) begin
        slot_code[i] <= dec_code;
        slot_err[i]  <= dec_err;
      end
    end
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    drop    = 1'b0;
    ack_clr = 1'b0;
    case (state)
      COLLECT: begin
        if (mask == 4'hF) begin
          load    = 1'b1;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (mask == 4'hF) begin
          if (ACK) begin
            load    = 1'b1;
            ack_clr = 1'b1;
          end else begin
            drop    = 1'b1;
          end
        end else if (ACK) begin
          ack_clr = 1'b1;
          state_n = COLLECT;
        end
      end
      default: state_n = COLLECT;
    endcase
  end

  // Frame assembly: a capture on the same edge as a frame hand-off starts the next frame
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= COLLECT;
      stab_cnt <= 8'd0;
      mask     <= 4'd0;
      OUT      <= 16'hFFFF;
      ERR      <= 1'b0;
      OVR      <= 1'b0;
    end else begin
      state    <= state_n;
      stab_cnt <= stab_cnt_n;
      mask     <= ((load || drop) ? 4'd0 : mask) | (capture ? dig_p1 : 4'd0);
      if (load) begin
        OUT <= {slot_code[3], slot_code[2], slot_code[1], slot_code[0]};
        ERR <= |slot_err;
      end
      if (ack_clr) begin
        OVR <= 1'b0;
      end else if (drop) begin
        OVR <= 1'b1;
      end
    end
  end

  assign VALID = (state == HOLD);

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Bench for seg7_scan_reader: directed scenarios plus randomized scanning against a dwell/frame reference model.
module tb_seg7_scan_reader;

  localparam int N = 4;
  localparam logic [6:0] PAT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  localparam logic [6:0] DASH  = 7'h40;
  localparam logic [6:0] BLANK = 7'h00;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  seg = '0;
  logic [3:0]  dig = '0;
  logic        ack = 1'b0;
  logic [15:0] out;
  logic        valid, err, ovr;

  int n_tests = 0;
  int n_fail  = 0;

  seg7_scan_reader #(.STABLE_CNT(N)) dut (
    .CLK   (clk),
    .RST   (rst),
    .SEG   (seg),
    .DIG   (dig),
    .OUT   (out),
    .VALID (valid),
    .ACK   (ack),
    .ERR   (err),
    .OVR   (ovr)
  );

  always #5 clk = ~clk;

  // Reference decode: {err, code}
  function automatic logic [4:0] ref_decode(input logic [6:0] s);
    for (int k = 0; k < 10; k++) if (PAT[k] == s) return {1'b0, 4'(k)};
    if (s == DASH) return {1'b0, 4'hE};
`ifdef SEG7_BLANK_DETECT_EN
    if (s == BLANK) return {1'b0, 4'hA};
`endif
    return {1'b1, 4'hF};
  endfunction

  // Reference model: inputs reach the logic two edges late; a digit is taken when its
  // unbroken one-hot dwell length equals N; frames follow the valid/ack rules.
  logic [6:0]  q_seg [3];
  logic [3:0]  q_dig [3];
  int          run;
  logic [3:0]  m_mask;
  logic [3:0]  m_slot [4];
  logic [3:0]  m_slerr;
  logic [15:0] m_out;
  logic        m_valid, m_err, m_ovr;

  always @(posedge clk) begin
    logic [6:0] xs;
    logic [3:0] xd;
    logic [4:0] dec;
    bit         full, cap;
    if (rst) begin
      for (int i = 0; i < 3; i++) begin q_seg[i] = '0; q_dig[i] = '0; end
      run = 0; m_mask = '0; m_out = 16'hFFFF; m_valid = 0; m_err = 0; m_ovr = 0;
    end else begin
      xs = q_seg[1]; xd = q_dig[1]; cap = 0;
      if ($onehot(xd)) begin
        run = (xs == q_seg[2] && xd == q_dig[2]) ? run + 1 : 1;
        cap = (run == N);
      end else begin
        run = 0;
      end
      full = (m_mask == 4'hF);
      if (full && (!m_valid || ack)) begin
        m_out = {m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
        m_err = |m_slerr; m_valid = 1; m_ovr = 0;
      end else if (full) begin
        m_ovr = 1;
      end else if (m_valid && ack) begin
        m_valid = 0; m_ovr = 0;
      end
      if (full) m_mask = '0;
      if (cap) begin
        dec = ref_decode(xs);
        for (int i = 0; i < 4; i++) if (xd[i]) begin
          m_slot[i] = dec[3:0]; m_slerr[i] = dec[4]; m_mask[i] = 1'b1;
        end
      end
      q_seg[2] = q_seg[1]; q_seg[1] = q_seg[0]; q_seg[0] = seg;
      q_dig[2] = q_dig[1]; q_dig[1] = q_dig[0]; q_dig[0] = dig;
    end
  end

  task automatic dwell(input logic [3:0] d, input logic [6:0] s, input int n);
    dig = d; seg = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input logic [6:0] s0, input logic [6:0] s1,
                      input logic [6:0] s2, input logic [6:0] s3, input int n);
    dwell(4'b0001, s0, n); dwell(4'b0010, s1, n);
    dwell(4'b0100, s2, n); dwell(4'b1000, s3, n);
  endtask

  task automatic idle(input int n);
    dwell(4'b0000, 7'h00, n);
  endtask

  task automatic pulse_ack();
    ack = 1'b1; @(negedge clk); ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ack = 1'b1; dig = 4'b0001; seg = PAT[1];
    repeat (3) @(negedge clk);
    rst = 1'b0; ack = 1'b0; idle(1);
    n_tests++; if (out !== 16'hFFFF) begin n_fail++; $display("FAIL reset_out: got %h want ffff", out); end
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    n_tests++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %b want 0", ovr); end
  endtask

  task automatic test_basic_scan();
    scan(PAT[1], PAT[2], PAT[3], PAT[4], 10); idle(2);
    n_tests++; if (valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", valid); end
    n_tests++; if (out !== 16'h4321) begin n_fail++; $display("FAIL basic_out: got %h want 4321", out); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b want 0", err); end
    n_tests++; if (out !== m_out) begin n_fail++; $display("FAIL basic_model_out: got %h want %h", out, m_out); end
    pulse_ack(); idle(1);
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL basic_ack_valid: got %b want 0", valid); end
  endtask

  task automatic test_short_dwell();
    dwell(4'b0001, PAT[5], 10); dwell(4'b0010, PAT[6], 10);
    dwell(4'b0100, PAT[7], 3);  dwell(4'b1000, PAT[8], 10); idle(4);
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL short_no_valid: got %b want 0", valid); end
    dwell(4'b0100, PAT[7], 3); idle(4);
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL short_no_valid2: got %b want 0", valid); end
    dwell(4'b0100, PAT[7], 5); idle(3);
    n_tests++; if (valid !== 1'b1) begin n_fail++; $display("FAIL short_valid: got %b want 1", valid); end
    n_tests++; if (out !== 16'h8765) begin n_fail++; $display("FAIL short_out: got %h want 8765", out); end
    pulse_ack(); idle(1);
  endtask

  task automatic test_invalid_dash();
    scan(DASH, 7'b0101010, PAT[3], PAT[9], 10); idle(2);
    n_tests++; if (out[7:4] !== 4'hF) begin n_fail++; $display("FAIL inv_nibble: got %h want f", out[7:4]); end
    n_tests++; if (out !== 16'h93FE) begin n_fail++; $display("FAIL inv_out: got %h want 93fe", out); end
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL inv_err: got %b want 1", err); end
    pulse_ack();
    scan(PAT[1], DASH, PAT[2], PAT[3], 10); idle(2);
    n_tests++; if (out !== 16'h32E1) begin n_fail++; $display("FAIL dash_out: got %h want 32e1", out); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL dash_err: got %b want 0", err); end
    pulse_ack();
    scan(BLANK, PAT[1], PAT[1], PAT[1], 10); idle(2);
`ifdef SEG7_BLANK_DETECT_EN
    n_tests++; if (out !== 16'h111A || err !== 1'b0) begin n_fail++; $display("FAIL blank: got %h/%b want 111a/0", out, err); end
`else
    n_tests++; if (out !== 16'h111F || err !== 1'b1) begin n_fail++; $display("FAIL blank: got %h/%b want 111f/1", out, err); end
`endif
    pulse_ack(); idle(1);
  endtask

  task automatic test_overrun();
    scan(PAT[1], PAT[2], PAT[3], PAT[4], 10);
    scan(PAT[5], PAT[6], PAT[7], PAT[8], 10); idle(2);
    n_tests++; if (out !== 16'h4321) begin n_fail++; $display("FAIL ovr_out: got %h want 4321", out); end
    n_tests++; if (valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid: got %b want 1", valid); end
    n_tests++; if (ovr !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b want 1", ovr); end
    pulse_ack(); idle(1);
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL ovr_ack_valid: got %b want 0", valid); end
    n_tests++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL ovr_ack_ovr: got %b want 0", ovr); end
  endtask

  task automatic test_ack_coincide();
    scan(PAT[1], PAT[2], PAT[3], PAT[4], 10);
    scan(PAT[5], PAT[6], PAT[7], PAT[8], 10); idle(2);
    n_tests++; if (ovr !== 1'b1) begin n_fail++; $display("FAIL coin_pre_ovr: got %b want 1", ovr); end
    dwell(4'b0001, PAT[9], 10); dwell(4'b0010, PAT[0], 10); dwell(4'b0100, PAT[1], 10);
    dig = 4'b1000; seg = PAT[2];
    repeat (10) begin @(negedge clk); ack = (m_mask == 4'hF); end
    ack = 1'b0; idle(2);
    n_tests++; if (out !== 16'h2109) begin n_fail++; $display("FAIL coin_out: got %h want 2109", out); end
    n_tests++; if (valid !== 1'b1) begin n_fail++; $display("FAIL coin_valid: got %b want 1", valid); end
    n_tests++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL coin_ovr: got %b want 0", ovr); end
    pulse_ack(); idle(1);
  endtask

  task automatic test_reset_mid();
    scan(PAT[1], PAT[2], PAT[3], PAT[4], 10);
    scan(PAT[1], PAT[2], PAT[3], PAT[4], 10);
    dwell(4'b0001, PAT[1], 10); dwell(4'b0010, PAT[2], 10); dwell(4'b0100, PAT[3], 10);
    ack = 1'b1; do_reset(); ack = 1'b0;
    n_tests++; if (out !== 16'hFFFF) begin n_fail++; $display("FAIL rmid_out: got %h want ffff", out); end
    n_tests++; if (valid !== 1'b0 || ovr !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL rmid_flags: got v%b o%b e%b want 000", valid, ovr, err); end
    dwell(4'b1000, PAT[8], 10); idle(4);
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rmid_partial: got %b want 0", valid); end
    dwell(4'b0001, PAT[5], 10); dwell(4'b0010, PAT[6], 10); dwell(4'b0100, PAT[7], 10); idle(3);
    n_tests++; if (out !== 16'h8765 || valid !== 1'b1) begin
      n_fail++; $display("FAIL rmid_out2: got %h/%b want 8765/1", out, valid); end
    pulse_ack(); idle(1);
  endtask

  task automatic test_random();
    int r, n;
    logic [3:0] d;
    logic [6:0] s;
    for (int t = 0; t < 120; t++) begin
      r = $urandom_range(0, 13);
      s = (r < 10) ? PAT[r] : (r == 10) ? DASH : (r == 11) ? BLANK : 7'($urandom_range(0, 127));
      r = $urandom_range(0, 9);
      d = (r < 8) ? 4'(1 << (r % 4)) : 4'($urandom_range(0, 15));
      n = $urandom_range(1, 8);
      dig = d; seg = s;
      repeat (n) begin
        ack = ($urandom_range(0, 7) == 0);
        @(negedge clk);
        n_tests++; if (out !== m_out) begin n_fail++; $display("FAIL rand_out: got %h want %h", out, m_out); end
        n_tests++; if (valid !== m_valid) begin n_fail++; $display("FAIL rand_valid: got %b want %b", valid, m_valid); end
        n_tests++; if (err !== m_err) begin n_fail++; $display("FAIL rand_err: got %b want %b", err, m_err); end
        n_tests++; if (ovr !== m_ovr) begin n_fail++; $display("FAIL rand_ovr: got %b want %b", ovr, m_ovr); end
      end
    end
    ack = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic_scan();
    test_short_dwell();
    test_invalid_dash();
    test_overrun();
    test_ack_coincide();
    test_reset_mid();
    do_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_reader.md
SEG7_SCAN_READER -- requirements
Module: seg7_scan_reader

Interface
REQ-001 SHALL have parameter STABLE_CNT, default 4, meaning consecutive identical synchronised samples required before a digit is captured (legal 1..255).
REQ-002 SHALL have port CLK  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port SEG  input  7  segment lines gfedcba, active-high, asynchronous to CLK.
REQ-005 SHALL have port DIG  input  4  digit select, one-hot active-high, asynchronous to CLK; bit i selects digit i.
REQ-006 SHALL have port OUT  output  16  captured frame, digit i in bits [4i+3:4i].
REQ-007 SHALL have port VALID  output  1  OUT holds an unacknowledged frame.
REQ-008 SHALL have port ACK  input  1  consumer accepts the frame.
REQ-009 SHALL have port ERR  output  1  at least one digit of OUT held an unrecognised pattern.
REQ-010 SHALL have port OVR  output  1  sticky: a complete frame was dropped while VALID was high.

Function
REQ-011 SHALL pass SEG and DIG through a two-flop synchroniser; all following rules use synchronised values.
REQ-012 SHALL decode patterns 0-9 to codes 0-9 (0111111=0, 0000110=1, 1011011=2, 1001111=3, 1100110=4, 1101101=5, 1111101=6, 0000111=7, 1111111=8, 1101111=9), dash 1000000 to 4'hE, any other pattern to 4'hF with a per-digit error flag.
REQ-013 SHALL increment an 8-bit saturating stability counter while DIG is one-hot and both DIG and SEG equal their previous-cycle values; any change or non-one-hot DIG reloads it to 1 (one-hot) or 0 (not one-hot).
REQ-014 SHALL capture the decoded digit into slot i and set mask bit i exactly once per dwell, on the cycle the counter reaches STABLE_CNT; no re-capture until DIG or SEG changes.
REQ-015 SHALL overwrite slot i with the newer value if digit i is captured again before the frame completes.
REQ-016 SHALL use two states: COLLECT (VALID=0) and HOLD (VALID=1); capture continues in both.
REQ-017 SHALL, when the mask reaches 1111 in COLLECT, on the next edge load OUT and ERR from the slots, set VALID, clear the mask, enter HOLD.
REQ-018 SHALL, on ACK high in HOLD, clear VALID and OVR and return to COLLECT on the next edge.
REQ-019 SHALL, when the mask reaches 1111 in HOLD without ACK, discard that frame, clear the mask, set OVR, keep OUT unchanged.
REQ-020 SHALL, when frame completion and ACK coincide in HOLD, load the new frame, keep VALID=1, clear OVR.
REQ-021 SHALL ignore ACK in COLLECT.
REQ-022 SHALL keep OUT and ERR stable while VALID=1 except per REQ-020.

Reset
REQ-023 SHALL on RST: OUT=16'hFFFF, VALID=0, ERR=0, OVR=0, mask=0, counter=0, synchronisers=0, state COLLECT; RST overrides ACK and captures in the same cycle.
REQ-024 SHALL discard any partial frame on RST mid-collection.

Configuration
REQ-025 SHALL with SEG7_BLANK_DETECT_EN defined decode 0000000 to 4'hA without error flag; without it 0000000 decodes to 4'hF with error flag.

Structure
REQ-026 SHALL take segment pattern constants (digits 0-9, dash, blank) and codes (4'hA blank, 4'hE dash, 4'hF invalid) from shared package seg7_pkg.
REQ-027 SHALL place pattern-to-code decoding in combinational sub-module seg7_to_bcd (7-bit in, 4-bit code, 1-bit error).

Verification
REQ-028 SHALL cover: scan 1,2,3,4 on DIG 0001..1000, each 10 cycles, STABLE_CNT=4 -> VALID=1, OUT=16'h4321, ERR=0.
REQ-029 SHALL cover: digit 2 dwell of 3 cycles only (STABLE_CNT=4) -> no VALID until digit 2 rescanned for >=4 cycles.
REQ-030 SHALL cover: digit 1 pattern 0101010 -> OUT[7:4]=4'hF, ERR=1; dash -> 4'hE, ERR=0.
REQ-031 SHALL cover: two full frames with ACK held low -> OUT keeps first frame, OVR=1; ACK -> VALID=0, OVR=0.
REQ-032 SHALL cover: ACK asserted on completion cycle of second frame -> OUT updates, VALID stays 1, OVR=0.
REQ-033 SHALL cover: RST after 3 digits captured -> all outputs reset; next full scan 5,6,7,8 yields OUT=16'h8765.
